// File: rtl/alu_pkg.sv
// Shared definitions for the Z-register ALU slice.
// Holds the operand width, the MUL/DIV iteration count, the opcode map, the
// control FSM state encoding, and the 32-bit NOT unit used by the ALU mux.
package alu_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Bitwise complement unit of the datapath.
  function automatic logic [WIDTH-1:0] not_32(input logic [WIDTH-1:0] x);
    return ~x;
  endfunction

endpackage

// File: rtl/mul_div_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) datapath.
// Ports:
//   clock, clear        rising-edge clock, async active-high reset
//   start_mul/start_div latch operands and clear the step counter
//   a, b                operands (multiplier/multiplicand, dividend/divisor)
//   step                perform one iteration
//   hi, lo              result: product {hi,lo}, or remainder/quotient
//   last                all ITER iterations done
module mul_div_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);
  import alu_pkg::*;

  // acc: Booth accumulator (one guard bit so the most negative multiplicand
  // cannot overflow) or restoring-division partial remainder.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;       // multiplier / dividend magnitude -> quotient
  logic [WIDTH-1:0] m;       // multiplicand / divisor magnitude
  logic [WIDTH-1:0] a_raw;   // original dividend, returned on divide-by-zero
  logic             q_m1;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   booth_c;
  logic [WIDTH:0]   rem_sh_c;
  logic [WIDTH:0]   diff_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;

  // Per-iteration arithmetic for both algorithms.
  always_comb begin
    booth_c  = acc;
    case ({q[0], q_m1})
      2'b01:   booth_c = acc + {m[WIDTH-1], m};
      2'b10:   booth_c = acc - {m[WIDTH-1], m};
      default: booth_c = acc;
    endcase
    rem_sh_c = {acc[WIDTH-1:0], q[WIDTH-1]};
    diff_c   = rem_sh_c - {1'b0, m};
    a_mag_c  = a[WIDTH-1] ? ('0 - a) : a;
    b_mag_c  = b[WIDTH-1] ? ('0 - b) : b;
  end

  // Operand latch and iteration registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      a_raw  <= '0;
      q_m1   <= 1'b0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      cnt    <= '0;
    end else if (start_mul) begin
      acc    <= '0;
      q      <= a;
      m      <= b;
      q_m1   <= 1'b0;
      is_div <= 1'b0;
      cnt    <= '0;
    end else if (start_div) begin
      acc    <= '0;
      q      <= a_mag_c;
      m      <= b_mag_c;
      a_raw  <= a;
      q_m1   <= 1'b0;
      is_div <= 1'b1;
      neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r  <= a[WIDTH-1];
      b_zero <= (b == '0);
      cnt    <= '0;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
      if (is_div) begin
        // Keep the trial subtraction only when it did not go negative.
        if (!diff_c[WIDTH]) begin
          acc <= diff_c;
          q   <= {q[WIDTH-2:0], 1'b1};
        end else begin
          acc <= rem_sh_c;
          q   <= {q[WIDTH-2:0], 1'b0};
        end
      end else begin
        // Arithmetic right shift of {acc, q, q_m1}.
        acc  <= {booth_c[WIDTH], booth_c[WIDTH:1]};
        q    <= {booth_c[0], q[WIDTH-1:1]};
        q_m1 <= q[0];
      end
    end
  end

  assign last = (cnt == CNT_W'(ITER));

  // Result selection with sign fix-up for division.
  always_comb begin
    hi = acc[WIDTH-1:0];
    lo = q;
    if (is_div) begin
      if (b_zero) begin
        hi = a_raw;
        lo = '1;
      end else begin
        hi = neg_r ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        lo = neg_q ? ('0 - q) : q;
      end
    end
  end

endmodule

// File: rtl/alu_z_unit.sv
// Sequential ALU wrapper driving the 64-bit Z register pair.
// Ports:
//   clock, clear   rising-edge clock, async active-high reset
//   start, op      launch request and opcode (sampled in IDLE only)
//   A, B           operand A (Y register), operand B (bus)
//   busy           MUL/DIV in flight
//   done           one-cycle pulse when z_hi/z_lo update
//   z_hi, z_lo     result words (DIV: remainder / quotient)
module alu_z_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo
);
  import alu_pkg::*;

  localparam int unsigned SH_W = $clog2(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   alu_c;
  logic [2*WIDTH-1:0] rot_c;
  logic [SH_W-1:0]    sh;
  logic [WIDTH-1:0]   seq_hi;
  logic [WIDTH-1:0]   seq_lo;
  logic               seq_last;
  logic               start_mul_c;
  logic               start_div_c;
  logic               step_c;

  assign sh = B[SH_W-1:0];

  // Single-cycle units; undefined opcodes produce zero.
  always_comb begin
    alu_c = '0;
    rot_c = '0;
    case (op)
      OP_ADD:  alu_c = A + B;
      OP_SUB:  alu_c = A - B;
      OP_AND:  alu_c = A & B;
      OP_OR:   alu_c = A | B;
      OP_SHR:  alu_c = A >> sh;
      OP_SHRA: alu_c = WIDTH'($signed(A) >>> sh);
      OP_SHL:  alu_c = A << sh;
      OP_ROR: begin
        rot_c = {A, A} >> sh;
        alu_c = rot_c[WIDTH-1:0];
      end
      OP_ROL: begin
        rot_c = {A, A} << sh;
        alu_c = rot_c[2*WIDTH-1:WIDTH];
      end
      OP_NEG:  alu_c = '0 - B;
      OP_NOT:  alu_c = not_32(B);
      default: alu_c = '0;
    endcase
  end

  assign start_mul_c = (state == ST_IDLE) && start && (op == OP_MUL);
  assign start_div_c = (state == ST_IDLE) && start && (op == OP_DIV);
  assign step_c      = ((state == ST_MUL) || (state == ST_DIV)) && !seq_last;

  mul_div_seq #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_mul_div_seq (
    .clock     (clock),
    .clear     (clear),
    .start_mul (start_mul_c),
    .start_div (start_div_c),
    .a         (A),
    .b         (B),
    .step      (step_c),
    .hi        (seq_hi),
    .lo        (seq_lo),
    .last      (seq_last)
  );

  // Control FSM, handshake and Z registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      z_hi  <= '0;
      z_lo  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              state <= ST_MUL;
              busy  <= 1'b1;
            end else if (op == OP_DIV) begin
              state <= ST_DIV;
              busy  <= 1'b1;
            end else begin
              z_hi <= '0;
              z_lo <= alu_c;
              done <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (seq_last) state <= ST_FIN;
        end
        ST_FIN: begin
          z_hi  <= seq_hi;
          z_lo  <= seq_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
